// File: rtl/dlx_fetch_unit.sv
// DLX instruction fetch stage: owns the PC, issues one word request at a time to
// instruction memory, hands each instruction to decode and applies redirects from execute.
module dlx_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0015
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4,
    input  logic        id_ready,
    input  logic        ex_valid,
    input  logic        ex_beqz,
    input  logic        ex_bnez,
    input  logic        ex_jump,
    input  logic        ex_jumpReg,
    input  logic [31:0] ex_rs1,
    input  logic [25:0] ex_offset,
    input  logic [31:0] ex_pc4
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      state_r, state_next_s;
    logic [31:0] pc_r, pc_next_s;
    logic [31:0] instr_r, instr_next_s;
    logic [31:0] pc4_r, pc4_next_s;
    logic        valid_r, valid_next_s;
    logic        req_r, req_next_s;
    logic        gnt_s;
    logic        taken_s;
    logic [31:0] target_s;

    // Jumps use the full 26-bit offset, branches the low 16 bits; result is word aligned.
    function automatic logic [31:0] redirect_target(
        input logic        jump_reg,
        input logic        jump,
        input logic [31:0] rs1,
        input logic [25:0] offset,
        input logic [31:0] pc4
    );
        logic [31:0] ext;
        logic [31:0] sum;
        if (jump) begin
            ext = {{6{offset[25]}}, offset};
        end else begin
            ext = {{16{offset[15]}}, offset[15:0]};
        end
        if (jump_reg) begin
            sum = rs1;
        end else begin
            sum = pc4 + ext;
        end
        return {sum[31:2], 2'b00};
    endfunction

    assign taken_s  = ex_valid & (ex_jump
                                  | (ex_beqz & (ex_rs1 == 32'd0))
                                  | (ex_bnez & (ex_rs1 != 32'd0)));
    assign target_s = redirect_target(ex_jumpReg, ex_jump, ex_rs1, ex_offset, ex_pc4);
    // A grant only counts while our request is actually visible on the bus.
    assign gnt_s    = req_r & imem_gnt;

    // Next-state, PC and decode-output selection; a taken redirect overrides all else.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        instr_next_s = instr_r;
        pc4_next_s   = pc4_r;
        valid_next_s = valid_r;
        case (state_r)
            S_REQ: begin
                if (taken_s) begin
                    pc_next_s    = target_s;
                    state_next_s = gnt_s ? S_DROP : S_REQ;
                end else if (gnt_s) begin
                    state_next_s = S_WAIT;
                end else begin
                    state_next_s = S_REQ;
                end
            end
            S_WAIT: begin
                if (taken_s) begin
                    pc_next_s    = target_s;
                    state_next_s = imem_rvalid ? S_REQ : S_DROP;
                end else if (imem_rvalid) begin
                    instr_next_s = imem_rdata;
                    pc4_next_s   = pc_r + 32'd4;
                    valid_next_s = 1'b1;
                    pc_next_s    = pc_r + 32'd4;
                    state_next_s = S_HOLD;
                end else begin
                    state_next_s = S_WAIT;
                end
            end
            S_HOLD: begin
                if (taken_s) begin
                    pc_next_s    = target_s;
                    valid_next_s = 1'b0;
                    instr_next_s = NOP_WORD;
                    state_next_s = S_REQ;
                end else if (id_ready) begin
                    valid_next_s = 1'b0;
                    instr_next_s = NOP_WORD;
                    state_next_s = S_REQ;
                end else begin
                    state_next_s = S_HOLD;
                end
            end
            S_DROP: begin
                if (taken_s) begin
                    pc_next_s = target_s;
                end else begin
                    pc_next_s = pc_r;
                end
                // The stale response still has to be absorbed before a new request.
                state_next_s = imem_rvalid ? S_REQ : S_DROP;
            end
            default: begin
                state_next_s = S_REQ;
            end
        endcase
        req_next_s = (state_next_s == S_REQ);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_REQ;
            pc_r    <= RESET_PC;
            instr_r <= NOP_WORD;
            pc4_r   <= 32'd0;
            valid_r <= 1'b0;
            req_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            pc_r    <= pc_next_s;
            instr_r <= instr_next_s;
            pc4_r   <= pc4_next_s;
            valid_r <= valid_next_s;
            req_r   <= req_next_s;
        end
    end

    assign imem_req  = req_r;
    assign imem_addr = pc_r;
    assign if_valid  = valid_r;
    assign if_instr  = instr_r;
    assign if_pc4    = pc4_r;

endmodule

// File: tb/tb_dlx_fetch_unit.sv
// Self-checking bench for dlx_fetch_unit: directed scenarios plus a randomized phase,
// scored against a queue-based model of fetched addresses and delivered instructions.
module tb_dlx_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0015;

    logic        clk = 1'b0;
    logic        reset, imem_req, imem_gnt, imem_rvalid, if_valid, id_ready;
    logic        ex_valid, ex_beqz, ex_bnez, ex_jump, ex_jumpReg;
    logic [31:0] imem_addr, imem_rdata, if_instr, if_pc4, ex_rs1, ex_pc4;
    logic [25:0] ex_offset;

    dlx_fetch_unit #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4), .id_ready(id_ready),
        .ex_valid(ex_valid), .ex_beqz(ex_beqz), .ex_bnez(ex_bnez), .ex_jump(ex_jump),
        .ex_jumpReg(ex_jumpReg), .ex_rs1(ex_rs1), .ex_offset(ex_offset), .ex_pc4(ex_pc4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // memory model state
    logic        fixed_mode = 1'b1;
    int          lat = 1;
    logic        pend = 1'b0;
    int          wait_left = 0;
    logic [31:0] pend_addr = 32'd0;

    // reference model state
    logic [31:0] exp_fetch = RESET_PC;
    logic [31:0] exp_q[$];
    logic [31:0] fire_log[$];
    logic [31:0] acc_instr[$];
    logic [31:0] acc_pc4[$];
    logic        last_fire = 1'b0;
    logic [31:0] last_fire_addr = 32'd0;

    function automatic logic [31:0] memdata(input logic [31:0] a);
        if (fixed_mode) return 32'h2001_0005;
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] ref_target(input logic jr, input logic j,
                                               input logic [31:0] rs1, input logic [25:0] off,
                                               input logic [31:0] pc4);
        logic [31:0] t;
        if (jr) t = rs1;
        else if (j) t = pc4 + 32'($signed(off));
        else t = pc4 + 32'($signed(off[15:0]));
        return t & 32'hFFFF_FFFC;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: score the pre-edge handshakes, advance, then drive memory for the next cycle.
    task automatic tick();
        logic fire, acc, tk;
        logic [31:0] fa, tg;
        fire = !reset && imem_req && imem_gnt;
        fa   = imem_addr;
        acc  = !reset && if_valid && id_ready;
        tk   = !reset && ex_valid && (ex_jump || (ex_beqz && ex_rs1 == 32'd0)
                                      || (ex_bnez && ex_rs1 != 32'd0));
        tg   = ref_target(ex_jumpReg, ex_jump, ex_rs1, ex_offset, ex_pc4);
        if (fire) begin
            check("one_outstanding", {31'd0, pend}, 32'd0);
            check("fetch_addr", fa, exp_fetch);
            fire_log.push_back(fa);
            if (!tk) exp_q.push_back(fa);
            exp_fetch = fa + 32'd4;
        end
        if (acc && !tk) begin
            check("held_count", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) begin
                check("instr", if_instr, memdata(exp_q[0]));
                check("pc4", if_pc4, exp_q[0] + 32'd4);
                void'(exp_q.pop_front());
            end
            acc_instr.push_back(if_instr);
            acc_pc4.push_back(if_pc4);
        end
        if (tk) begin
            exp_q.delete();
            exp_fetch = tg;
        end
        @(posedge clk);
        #1;
        if (imem_rvalid) begin
            pend = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end
        if (fire) begin
            pend = 1'b1;
            pend_addr = fa;
            wait_left = lat;
        end
        if (pend) begin
            if (wait_left == 1) begin
                imem_rvalid = 1'b1;
                imem_rdata = memdata(pend_addr);
            end else begin
                wait_left--;
            end
        end
        if (!if_valid) check("nop_when_idle", if_instr, NOP_WORD);
        last_fire = fire;
        last_fire_addr = fa;
    endtask

    task automatic wait_fire(input string tag);
        int n = 0;
        last_fire = 1'b0;
        while (!last_fire && n < 60) begin
            tick();
            n++;
        end
        check(tag, {31'd0, last_fire}, 32'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!if_valid && n < 60) begin
            tick();
            n++;
        end
        check(tag, {31'd0, if_valid}, 32'd1);
    endtask

    task automatic redirect(input logic jr, input logic j, input logic bz, input logic bnz,
                            input logic [31:0] rs1, input logic [25:0] off,
                            input logic [31:0] pc4);
        ex_valid = 1'b1; ex_jumpReg = jr; ex_jump = j; ex_beqz = bz; ex_bnez = bnz;
        ex_rs1 = rs1; ex_offset = off; ex_pc4 = pc4;
        tick();
        ex_valid = 1'b0; ex_jumpReg = 1'b0; ex_jump = 1'b0; ex_beqz = 1'b0; ex_bnez = 1'b0;
    endtask

    initial begin
        int n, saved, prev_v, pulse_err;
        reset = 1'b1; imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        id_ready = 1'b1; ex_valid = 1'b0; ex_beqz = 1'b0; ex_bnez = 1'b0; ex_jump = 1'b0;
        ex_jumpReg = 1'b0; ex_rs1 = 32'd0; ex_offset = 26'd0; ex_pc4 = 32'd0;

        // reset state and request timing
        repeat (3) tick();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_instr", if_instr, NOP_WORD);
        check("rst_pc4", if_pc4, 32'd0);
        check("rst_addr", imem_addr, RESET_PC);
        reset = 1'b0;
        check("req_low_release", {31'd0, imem_req}, 32'd0);
        tick();
        check("req_rises", {31'd0, imem_req}, 32'd1);

        // 1: back-to-back sequential fetch with zero wait
        n = 0; prev_v = 0; pulse_err = 0;
        while (fire_log.size() < 3 && n < 40) begin
            tick();
            if (if_valid && prev_v != 0) pulse_err++;
            prev_v = int'(if_valid);
            n++;
        end
        check("t1_fires", 32'(fire_log.size()), 32'd3);
        check("t1_pulse", 32'(pulse_err), 32'd0);
        if (fire_log.size() >= 3) begin
            check("t1_addr0", fire_log[0], 32'h0);
            check("t1_addr1", fire_log[1], 32'h4);
            check("t1_addr2", fire_log[2], 32'h8);
        end
        check("t1_accepts", 32'(acc_instr.size()), 32'd2);
        if (acc_instr.size() >= 1) begin
            check("t1_instr", acc_instr[0], 32'h2001_0005);
            check("t1_pc4", acc_pc4[0], 32'h4);
        end

        // 2: decode stall in HOLD
        id_ready = 1'b0;
        wait_valid("t2_valid");
        saved = fire_log.size();
        repeat (5) begin
            tick();
            check("t2_valid_hold", {31'd0, if_valid}, 32'd1);
            check("t2_instr_hold", if_instr, 32'h2001_0005);
            check("t2_pc4_hold", if_pc4, 32'hC);
            check("t2_req_low", {31'd0, imem_req}, 32'd0);
        end
        check("t2_no_fetch", 32'(fire_log.size()), 32'(saved));

        // 3: beqz taken then not taken
        fixed_mode = 1'b0;
        redirect(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 26'h000_FFF0, 32'h40);
        check("t3_flush", {31'd0, if_valid}, 32'd0);
        wait_fire("t3_fire_t");
        check("t3_taken_addr", last_fire_addr, 32'h30);
        wait_valid("t3_valid");
        redirect(1'b0, 1'b0, 1'b1, 1'b0, 32'd5, 26'h000_FFF0, 32'h40);
        check("t3_untaken_kept", {31'd0, if_valid}, 32'd1);
        check("t3_untaken_pc4", if_pc4, 32'h34);
        id_ready = 1'b1;
        wait_fire("t3_fire_nt");
        check("t3_seq_addr", last_fire_addr, 32'h34);

        // 4: JR with misaligned register, then J flushing a held instr despite id_ready
        id_ready = 1'b0;
        wait_valid("t4_valid_a");
        redirect(1'b1, 1'b1, 1'b0, 1'b0, 32'h1003, 26'd0, 32'h0);
        wait_fire("t4_fire_jr");
        check("t4_jr_addr", last_fire_addr, 32'h1000);
        wait_valid("t4_valid_b");
        id_ready = 1'b1;
        redirect(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 26'h000_0100, 32'h8);
        check("t4_flush", {31'd0, if_valid}, 32'd0);
        wait_fire("t4_fire_j");
        check("t4_j_addr", last_fire_addr, 32'h108);

        // 5: redirect while waiting on a slow response
        lat = 3;
        wait_fire("t5_fire_a");
        saved = acc_instr.size();
        redirect(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 26'h000_0100, 32'h100);
        wait_fire("t5_fire_b");
        check("t5_target", last_fire_addr, 32'h200);
        check("t5_no_delivery", 32'(acc_instr.size()), 32'(saved));

        // 6: reset during WAIT with response arriving inside reset
        wait_fire("t6_fire_a");
        reset = 1'b1;
        repeat (4) tick();
        check("t6_rst_valid", {31'd0, if_valid}, 32'd0);
        check("t6_rst_req", {31'd0, imem_req}, 32'd0);
        exp_q.delete();
        exp_fetch = RESET_PC;
        reset = 1'b0;
        wait_fire("t6_fire_b");
        check("t6_addr", last_fire_addr, RESET_PC);
        wait_valid("t6_valid");
        check("t6_pc4", if_pc4, RESET_PC + 32'd4);

        // randomized traffic, stalls and redirects
        for (int i = 0; i < 800; i++) begin
            int kind;
            imem_gnt = 1'($urandom_range(0, 1));
            lat = $urandom_range(1, 4);
            id_ready = ($urandom_range(0, 2) != 0);
            kind = $urandom_range(0, 4);
            ex_valid = ($urandom_range(0, 7) == 0);
            ex_beqz = (kind == 0); ex_bnez = (kind == 1);
            ex_jump = (kind == 2 || kind == 3); ex_jumpReg = (kind == 3);
            ex_rs1 = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
            ex_offset = 26'($urandom);
            ex_pc4 = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        ex_valid = 1'b0; imem_gnt = 1'b1; id_ready = 1'b1;
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
